// File: rtl/hack_cpu_mc.sv
// Multi-cycle Hack CPU: FETCH/EXEC/WAIT sequencer with handshaked instruction and data memory.
// Define HACK_CPU_MC_INSTRET_EN to build the 32-bit retired-instruction counter on instret.
module hack_cpu_mc #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned ADDR_WIDTH = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      instruction,
    input  logic                  instr_valid,
    output logic                  fetch_req,
    input  logic [WIDTH-1:0]      inM,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic [WIDTH-1:0]      outM,
    output logic                  writeM,
    output logic [ADDR_WIDTH-1:0] addressM,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [31:0]           instret
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [WIDTH-1:0]      ir_q, ir_d;
    logic [WIDTH-1:0]      a_q, a_d;
    logic [WIDTH-1:0]      d_q, d_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  commit;

    logic is_c, sel_m, dst_a, dst_d, dst_m, mem_op;
    assign is_c   = ir_q[WIDTH-1];
    assign sel_m  = ir_q[12];
    assign dst_a  = ir_q[5];
    assign dst_d  = ir_q[4];
    assign dst_m  = ir_q[3];
    assign mem_op = is_c & (sel_m | dst_m);

    // Hack ALU: x = D, y = A or M
    logic [WIDTH-1:0] alu_x, alu_y, alu_out;
    logic             zr, ng, jump;
    always_comb begin
        alu_x = d_q;
        alu_y = sel_m ? inM : a_q;
        if (ir_q[11]) alu_x = '0;
        if (ir_q[10]) alu_x = ~alu_x;
        if (ir_q[9])  alu_y = '0;
        if (ir_q[8])  alu_y = ~alu_y;
        alu_out = ir_q[7] ? (alu_x + alu_y) : (alu_x & alu_y);
        if (ir_q[6])  alu_out = ~alu_out;
    end

    assign zr   = (alu_out == '0);
    assign ng   = alu_out[WIDTH-1];
    assign jump = (ir_q[2] & ng) | (ir_q[1] & zr) | (ir_q[0] & ~ng & ~zr);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
            ir_q    <= '0;
            a_q     <= '0;
            d_q     <= '0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            d_q     <= d_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        a_d       = a_q;
        d_d       = d_q;
        pc_d      = pc_q;
        commit    = 1'b0;
        fetch_req = 1'b0;
        mem_req   = 1'b0;
        writeM    = 1'b0;

        case (state_q)
            ST_FETCH: begin
                fetch_req = 1'b1;
                if (instr_valid) begin
                    ir_d    = instruction;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (mem_op) begin
                    mem_req = 1'b1;
                    writeM  = dst_m;
                    if (mem_ready) begin
                        commit  = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else begin
                    commit  = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_WAIT: begin
                mem_req = 1'b1;
                writeM  = dst_m;
                if (mem_ready) begin
                    commit  = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_FETCH;
        endcase

        // Reset kills the bus request immediately and suppresses any commit
        if (reset) begin
            mem_req = 1'b0;
            writeM  = 1'b0;
            commit  = 1'b0;
        end

        if (commit) begin
            if (!is_c) begin
                a_d  = ir_q;
                pc_d = pc_q + ADDR_WIDTH'(1);
            end else begin
                if (dst_a) a_d = alu_out;
                if (dst_d) d_d = alu_out;
                pc_d = jump ? a_q[ADDR_WIDTH-1:0] : pc_q + ADDR_WIDTH'(1);
            end
        end
    end

    assign outM     = alu_out;
    assign addressM = a_q[ADDR_WIDTH-1:0];
    assign pc       = pc_q;

`ifdef HACK_CPU_MC_INSTRET_EN
    logic [31:0] instret_q;
    always_ff @(posedge clk) begin
        if (reset)       instret_q <= '0;
        else if (commit) instret_q <= instret_q + 32'd1;
    end
    assign instret = instret_q;
`else
    assign instret = '0;
`endif

endmodule

// File: tb/tb_hack_cpu_mc.sv
// Self-checking bench for hack_cpu_mc: vector table plus hand sequences for reset, wrap and stall cases.
module tb_hack_cpu_mc;

`ifdef HACK_CPU_MC_INSTRET_EN
    localparam bit INSTRET_ON = 1'b1;
`else
    localparam bit INSTRET_ON = 1'b0;
`endif

    logic        clk, reset, instr_valid, mem_ready;
    logic [15:0] instruction, inM;
    logic        fetch_req, mem_req, writeM;
    logic [15:0] outM;
    logic [14:0] addressM, pc;
    logic [31:0] instret;

    hack_cpu_mc #(.WIDTH(16), .ADDR_WIDTH(15)) dut (
        .clk(clk), .reset(reset), .instruction(instruction), .instr_valid(instr_valid),
        .fetch_req(fetch_req), .inM(inM), .mem_ready(mem_ready), .mem_req(mem_req),
        .outM(outM), .writeM(writeM), .addressM(addressM), .pc(pc), .instret(instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] instr;
        int          nwait;
        logic [15:0] inm;
        logic        mem;
        logic        wm;
        logic [15:0] outm;
        logic [14:0] maddr;
        logic [14:0] epc;
        logic [14:0] ea;
    } vec_t;

    typedef struct {
        logic [14:0] epc;
        logic [14:0] ea;
    } sb_t;

    sb_t         sb_q[$];
    vec_t        tbl[18];
    int          n_vec, n_err;
    logic [14:0] cur_pc;
    int unsigned exp_commits;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_instret();
        return INSTRET_ON ? 32'(exp_commits) : 32'd0;
    endfunction

    function automatic vec_t av(input logic [15:0] ins, input logic [14:0] epc, input logic [14:0] ea);
        vec_t v;
        v.instr = ins; v.nwait = 0; v.inm = '0; v.mem = 1'b0; v.wm = 1'b0;
        v.outm = '0; v.maddr = '0; v.epc = epc; v.ea = ea;
        return v;
    endfunction

    function automatic vec_t mv(input logic [15:0] ins, input int nwait, input logic [15:0] inm,
                                input logic wm, input logic [15:0] outm, input logic [14:0] maddr,
                                input logic [14:0] epc, input logic [14:0] ea);
        vec_t v;
        v.instr = ins; v.nwait = nwait; v.inm = inm; v.mem = 1'b1; v.wm = wm;
        v.outm = outm; v.maddr = maddr; v.epc = epc; v.ea = ea;
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; instr_valid = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        cur_pc = '0;
        exp_commits = 0;
    endtask

    // Feed one instruction, stall the data bus nwait cycles, then check the retired state
    task automatic exec(input vec_t v, input string tag);
        int  guard;
        sb_t e;
        guard = 0;
        while (fetch_req !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, " fetch_wait"}, 32'(fetch_req), 32'd1);
        if (fetch_req !== 1'b1) return;
        instruction = v.instr;
        instr_valid = 1'b1;
        e.epc = v.epc;
        e.ea  = v.ea;
        sb_q.push_back(e);
        @(negedge clk);
        instr_valid = 1'b0;
        instruction = 16'($urandom);
        for (int k = 0; k <= v.nwait; k++) begin
            chk({tag, " busy_fetch_req"}, 32'(fetch_req), 32'd0);
            chk({tag, " mem_req"}, 32'(mem_req), 32'(v.mem));
            chk({tag, " writeM"}, 32'(writeM), 32'(v.wm));
            chk({tag, " pc_held"}, 32'(pc), 32'(cur_pc));
            if (v.mem) chk({tag, " addressM"}, 32'(addressM), 32'(v.maddr));
            if (v.wm)  chk({tag, " outM"}, 32'(outM), 32'(v.outm));
            mem_ready = v.mem && (k == v.nwait);
            inM = (k == v.nwait) ? v.inm : 16'($urandom);
            @(negedge clk);
        end
        mem_ready = 1'b0;
        inM = 16'($urandom);
        exp_commits++;
        chk({tag, " latency"}, 32'(fetch_req), 32'd1);
        chk({tag, " sb_nonempty"}, 32'(sb_q.size()), 32'd1);
        if (sb_q.size() == 0) return;
        e = sb_q.pop_front();
        chk({tag, " pc"}, 32'(pc), 32'(e.epc));
        chk({tag, " A"}, 32'(addressM), 32'(e.ea));
        chk({tag, " instret"}, instret, exp_instret());
        cur_pc = e.epc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; instr_valid = 1'b0; mem_ready = 1'b0;
        instruction = '0; inM = '0;
        n_vec = 0; n_err = 0; cur_pc = '0; exp_commits = 0;

        tbl[0]  = av(16'h0005, 15'd1, 15'd5);                                       // @5
        tbl[1]  = av(16'hEC10, 15'd2, 15'd5);                                       // D=A
        tbl[2]  = mv(16'hE308, 3, 16'h0, 1'b1, 16'h0005, 15'd5, 15'd3, 15'd5);      // M=D, 3 stalls
        tbl[3]  = av(16'h0007, 15'd4, 15'd7);                                       // @7
        tbl[4]  = av(16'hEA90, 15'd5, 15'd7);                                       // D=0
        tbl[5]  = av(16'hEA82, 15'd7, 15'd7);                                       // 0;JEQ taken
        tbl[6]  = mv(16'hFC10, 1, 16'h1234, 1'b0, 16'h0, 15'd7, 15'd8, 15'd7);      // D=M
        tbl[7]  = mv(16'hE308, 0, 16'h0, 1'b1, 16'h1234, 15'd7, 15'd9, 15'd7);      // M=D
        tbl[8]  = mv(16'hE7EF, 2, 16'h0, 1'b1, 16'h1235, 15'd7, 15'd7, 15'h1235);   // AM=D+1;JMP
        tbl[9]  = av(16'h0003, 15'd8, 15'd3);                                       // @3
        tbl[10] = av(16'hEE90, 15'd9, 15'd3);                                       // D=-1
        tbl[11] = av(16'hE304, 15'd3, 15'd3);                                       // D;JLT taken
        tbl[12] = av(16'hE303, 15'd4, 15'd3);                                       // D;JGE not taken
        tbl[13] = av(16'hE0A0, 15'd5, 15'd2);                                       // A=D+A wraps
        tbl[14] = av(16'hE010, 15'd6, 15'd2);                                       // D=D&A
        tbl[15] = mv(16'hE4C8, 1, 16'h0, 1'b1, 16'h0000, 15'd2, 15'd7, 15'd2);      // M=D-A
        tbl[16] = av(16'hE350, 15'd8, 15'd2);                                       // D=!D
        tbl[17] = mv(16'hE308, 0, 16'h0, 1'b1, 16'hFFFD, 15'd2, 15'd9, 15'd2);      // M=D

        do_reset();
        chk("rst pc", 32'(pc), 32'd0);
        chk("rst fetch_req", 32'(fetch_req), 32'd1);
        chk("rst mem_req", 32'(mem_req), 32'd0);
        chk("rst writeM", 32'(writeM), 32'd0);
        chk("rst addressM", 32'(addressM), 32'd0);
        chk("rst instret", instret, 32'd0);

        for (int i = 0; i < 18; i++) exec(tbl[i], $sformatf("vec%0d", i));

        // Conditional jumps on zero result
        do_reset();
        exec(av(16'h0007, 15'd1, 15'd7), "jeq @7");
        exec(av(16'hEA90, 15'd2, 15'd7), "jeq D=0");
        exec(av(16'hEA82, 15'd7, 15'd7), "jeq 0;JEQ");
        do_reset();
        exec(av(16'h0007, 15'd1, 15'd7), "jgt @7");
        exec(av(16'hEA90, 15'd2, 15'd7), "jgt D=0");
        exec(av(16'hEA81, 15'd3, 15'd7), "jgt 0;JGT");

        // pc wraps from the top of the address space
        do_reset();
        exec(av(16'h7FFF, 15'd1, 15'h7FFF), "wrap @7FFF");
        exec(av(16'hEA87, 15'h7FFF, 15'h7FFF), "wrap 0;JMP");
        exec(av(16'h0000, 15'h0000, 15'h0000), "wrap @0");

        // Reset in the middle of a stalled write abandons it
        do_reset();
        exec(av(16'h0005, 15'd1, 15'd5), "rstw @5");
        exec(av(16'hEC10, 15'd2, 15'd5), "rstw D=A");
        instruction = 16'hE308;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        mem_ready = 1'b0;
        chk("rstw exec writeM", 32'(writeM), 32'd1);
        @(negedge clk);
        chk("rstw wait mem_req", 32'(mem_req), 32'd1);
        reset = 1'b1;
        #1;
        chk("rstw comb mem_req", 32'(mem_req), 32'd0);
        chk("rstw comb writeM", 32'(writeM), 32'd0);
        @(negedge clk);
        chk("rstw writeM", 32'(writeM), 32'd0);
        chk("rstw mem_req", 32'(mem_req), 32'd0);
        chk("rstw pc", 32'(pc), 32'd0);
        chk("rstw fetch_req", 32'(fetch_req), 32'd1);
        chk("rstw addressM", 32'(addressM), 32'd0);
        chk("rstw instret", instret, 32'd0);
        reset = 1'b0;
        cur_pc = '0;
        exp_commits = 0;
        exec(mv(16'hE308, 0, 16'h0, 1'b1, 16'h0000, 15'd0, 15'd1, 15'd0), "rstw D cleared");

        // Retired-instruction count over ten instructions
        do_reset();
        for (int i = 0; i < 10; i++) exec(av(16'(i + 1), 15'(i + 1), 15'(i + 1)), $sformatf("ret%0d", i));
        chk("instret after 10", instret, INSTRET_ON ? 32'd10 : 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hack_cpu_mc.md
HACK_CPU_MC -- requirements
Module: hack_cpu_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 16: data, A, D, ALU and instruction width (min 16).
REQ-002 SHALL have parameter ADDR_WIDTH, default 15: width of addressM and pc (≤ WIDTH-1).
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 instruction  in  WIDTH  instruction word for address pc.
REQ-006 instr_valid  in  1  instruction is valid this cycle.
REQ-007 fetch_req  out  1  core is in FETCH and waiting for an instruction.
REQ-008 inM  in  WIDTH  read data, Memory[addressM].
REQ-009 mem_ready  in  1  memory access completes this cycle.
REQ-010 mem_req  out  1  data-memory access pending.
REQ-011 outM  out  WIDTH  ALU result; write data.
REQ-012 writeM  out  1  write outM to Memory[addressM].
REQ-013 addressM  out  ADDR_WIDTH  A[ADDR_WIDTH-1:0].
REQ-014 pc  out  ADDR_WIDTH  address of the current or next instruction (registered).
REQ-015 instret  out  32  count of retired instructions (see Configuration).

Function
REQ-016 Decode: instruction[WIDTH-1]=0 is an A-instruction; =1 is a C-instruction. Control fields are at Hack bit positions: a=[12], c1..c6=[11:6], d1..d3=[5:3], j1..j3=[2:0].
REQ-017 The ALU SHALL implement the Hack zx/nx/zy/ny/f/no functions at WIDTH bits. x=D. y=A when a=0 and inM when a=1. zr=(out==0), ng=out[WIDTH-1].
REQ-018 The FSM SHALL have states FETCH, EXEC and WAIT. It SHALL leave reset in FETCH.
REQ-019 FETCH: fetch_req=1. When instr_valid=1, latch instruction into IR and go to EXEC; otherwise stay in FETCH.
REQ-020 EXEC, A-instruction or C-instruction with a=0 and d3=0: commit in this cycle (REQ-023) and go to FETCH.
REQ-021 EXEC, C-instruction with a=1 or d3=1: mem_req=1 and writeM=d3. If mem_ready=1, commit in this cycle and go to FETCH; otherwise go to WAIT.
REQ-022 WAIT: hold mem_req, writeM, addressM and outM stable until the cycle with mem_ready=1. Commit in that cycle and go to FETCH. inM SHALL be used only in the committing cycle.
REQ-023 Commit for an A-instruction: A<=IR.
REQ-024 Commit for a C-instruction:
- A<=ALU if d1=1.
- D<=ALU if d2=1.
- jump = (j1&ng)|(j2&zr)|(j3&~ng&~zr).
- pc<=A value from before the commit if jump=1; otherwise pc<=pc+1.
REQ-025 pc+1 SHALL wrap from 2^ADDR_WIDTH-1 to 0.
REQ-026 writeM and mem_req SHALL be 0 outside EXEC and WAIT, and 0 whenever reset=1.
REQ-027 Latency: an A-instruction or register-only C-instruction takes 2 cycles (FETCH with valid, then EXEC). A memory instruction takes 2+n cycles, where n is the number of not-ready cycles.
REQ-028 AM=...;JMP SHALL jump to the old A value and load the new A value.

Reset
REQ-029 reset=1 SHALL set A=0, D=0, IR=0, pc=0, instret=0 and state=FETCH at the next edge. It SHALL override instr_valid and mem_ready.
REQ-030 reset during WAIT SHALL abandon the access with no register or pc commit. The access SHALL NOT be retried.

Configuration
REQ-031 Macro HACK_CPU_MC_INSTRET_EN:
- When defined, instret SHALL increment by 1, wrapping at 2^32, on every commit.
- When undefined, instret SHALL be tied to 0 and the counter SHALL NOT be synthesised.

Verification
REQ-032 reset, then 0x0005 with valid -> after 2 cycles A=5, pc=1; writeM never 1.
REQ-033 @5; D=A (0xEC10); M=D (0xE308) with mem_ready low 3 cycles:
- writeM=1, addressM=5 and outM=5 held for 4 cycles.
- pc changes only after mem_ready.
REQ-034 @7; D=0 (0xEA90); 0;JEQ (0xEA82) -> pc=7. The same sequence with 0;JGT (0xEA81) -> pc=3.
REQ-035 pc=0x7FFF, non-jump instruction -> pc=0x0000.
REQ-036 reset asserted in WAIT -> next cycle: writeM=0, mem_req=0, pc=0, fetch_req=1, D=0.
REQ-037 10 instructions with HACK_CPU_MC_INSTRET_EN defined -> instret=10. The same run without the macro -> instret=0.
